// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver (8 data bits, 1 stop bit,
// LSB first) feeding a first-word-fall-through receive FIFO.
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frames; an even-parity bit follows bit 7 and a mismatch
//                discards the byte and pulses parity_err.
//   undefined -> 8N1 frames; parity_err is tied low.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_fifo_pop,
  output logic       rx_fifo_full,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       irq
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Synchronizer, oversampling tick and receive FSM state
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_s;
  state_t           state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             stop_smp_s;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Frame outcome and FIFO signals
  logic             perr_s;
  logic             push_req_s;
  logic             push_s;
  logic             pop_s;
  logic             ovr_s;
  logic             full_s;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             frame_err_q, overrun_q;

  assign rx_s   = sync_q[1];
  assign tick_s = (tick_cnt_q == DIV_W'(DIV - 1));

  // Two-flop synchronizer for the asynchronous serial line, preset to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  // Tick divider next state: parked at 0 while idle so the first start-bit tick is aligned
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (state_q == IDLE) begin
      tick_cnt_d = '0;
    end else if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + DIV_W'(1);
    end
  end

  // Receive FSM next state: counts ticks within each bit and samples at mid-bit
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    stop_smp_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          if (s_q == 4'd7) begin
            s_d = 4'd0;
            if (rx_s) begin
              state_d = IDLE;          // glitch shorter than half a bit
            end else begin
              state_d = DATA;
              bit_d   = 3'd0;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (s_q == 4'd15) begin
            s_d  = 4'd0;
            sh_d = {rx_s, sh_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          if (s_q == 4'd15) begin
            s_d     = 4'd0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          if (s_q == 4'd15) begin
            s_d        = 4'd0;
            stop_smp_s = 1'b1;
            state_d    = IDLE;         // re-arm at mid-stop for back-to-back frames
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 4'd0;
      end
    endcase
  end

  // Receive FSM and tick divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      s_q        <= 4'd0;
      bit_q      <= 3'd0;
      sh_q       <= 8'd0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      s_q        <= s_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign perr_s = (par_q != (^sh_q));
`else
  assign perr_s = 1'b0;
`endif

  // A byte is only offered to the FIFO when both stop and parity are good
  assign push_req_s = stop_smp_s & rx_s & ~perr_s;
  assign full_s     = (count_q == CW'(FIFO_DEPTH));
  assign pop_s      = rx_fifo_pop & rx_valid;
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign ovr_s      = push_req_s & full_s & ~pop_s;

  // FIFO pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO storage, pointers and registered error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= sh_q;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= stop_smp_s & ~rx_s;
      overrun_q   <= ovr_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  // Parity mismatch pulse, reported at the stop-bit sample
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= stop_smp_s & perr_s;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_byte      = mem_q[rd_ptr_q];
  assign rx_valid     = (count_q != '0);
  assign rx_fifo_full = full_s;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign irq          = rx_valid;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives serial frames on rx and checks the
// host-side FIFO interface and error pulses against hand-computed values.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 460800;                  // floor(50M/(460800*16)) = 6
  localparam int DIV    = 6;
  localparam int BIT    = 16 * DIV;                // clocks per serial bit
  localparam int POP_AT = 2 + 8 * DIV;             // stop-phase clock index of the stop sample edge
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_fifo_pop;
  logic       rx_fifo_full;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       irq;

  int n_checks = 0;
  int n_pass   = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int ovr_cnt  = 0;
  logic v_before, v_after;

  uart_rx_fifo #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_fifo_pop (rx_fifo_pop),
    .rx_fifo_full(rx_fifo_full),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Count high cycles of each error pulse; a correct one-clock pulse adds exactly one
  always @(posedge clk) begin
    if (!rst) begin
      if (frame_err)  ferr_cnt <= ferr_cnt + 1;
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (overrun)    ovr_cnt  <= ovr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame, inputs changed on falling edges; optional pop pulse during the stop bit
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip,
                            input int pop_at);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = (^d) ^ par_flip;
      repeat (BIT) @(negedge clk);
    end
    rx = stop_v;
    for (int c = 0; c < BIT; c++) begin
      if (c == POP_AT)     v_before = rx_valid;
      if (c == POP_AT + 1) v_after  = rx_valid;
      rx_fifo_pop = (c == pop_at);
      @(negedge clk);
    end
    rx_fifo_pop = 1'b0;
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check_eq({tag, "_byte"}, {24'd0, rx_byte}, {24'd0, exp});
    rx_fifo_pop = 1'b1;
    @(negedge clk);
    rx_fifo_pop = 1'b0;
  endtask

  initial begin
    rx          = 1'b1;
    rx_fifo_pop = 1'b0;
    rst         = 1'b1;
    v_before    = 1'b0;
    v_after     = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_byte",  {24'd0, rx_byte}, 32'h00);
    check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_full",  {31'd0, rx_fifo_full}, 32'd0);
    check_eq("rst_irq",   {31'd0, irq}, 32'd0);
    check_eq("rst_errs",  {29'd0, frame_err, parity_err, overrun}, 32'd0);
    rst = 1'b0;
    idle_bits(1);

    // 1: single byte, push latency, pop, pop on empty
    send_frame(8'h41, 1'b1, 1'b0, -1);
    check_eq("t1_lat_before", {31'd0, v_before}, 32'd0);
    check_eq("t1_lat_after",  {31'd0, v_after}, 32'd1);
    check_eq("t1_irq", {31'd0, irq}, 32'd1);
    pop_expect("t1", 8'h41);
    check_eq("t1_empty_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("t1_empty_irq",   {31'd0, irq}, 32'd0);
    rx_fifo_pop = 1'b1;
    @(negedge clk);
    rx_fifo_pop = 1'b0;
    check_eq("t1_pop_empty", {31'd0, rx_valid}, 32'd0);

    // 2: back-to-back frames with no idle gap
    send_frame(8'h58, 1'b1, 1'b0, -1);
    send_frame(8'h59, 1'b1, 1'b0, -1);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    check_eq("t2_errs", ferr_cnt + perr_cnt + ovr_cnt, 32'd0);
    pop_expect("t2_x", 8'h58);
    pop_expect("t2_y", 8'h59);
    pop_expect("t2_z", 8'h5A);
    check_eq("t2_empty", {31'd0, rx_valid}, 32'd0);

    // 3: short low glitch is rejected, next byte still received
    rx = 1'b0;
    repeat (8) @(negedge clk);
    idle_bits(2);
    check_eq("t3_nopush", {31'd0, rx_valid}, 32'd0);
    check_eq("t3_noerr", ferr_cnt + perr_cnt + ovr_cnt, 32'd0);
    send_frame(8'h55, 1'b1, 1'b0, -1);
    pop_expect("t3", 8'h55);

    // 4: framing error, then recovery
    send_frame(8'hA5, 1'b0, 1'b0, -1);
    idle_bits(2);
    check_eq("t4_ferr", ferr_cnt, 32'd1);
    check_eq("t4_nopush", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h96, 1'b1, 1'b0, -1);
    pop_expect("t4_next", 8'h96);

    // 5a: fill to full, ninth byte overruns and is dropped
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
    check_eq("t5_full", {31'd0, rx_fifo_full}, 32'd1);
    check_eq("t5_ovr_before", ovr_cnt, 32'd0);
    send_frame(8'h08, 1'b1, 1'b0, -1);
    check_eq("t5_ovr", ovr_cnt, 32'd1);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("t5a_%0d", i), 8'(i));
    check_eq("t5a_empty", {31'd0, rx_valid}, 32'd0);
    check_eq("t5a_notfull", {31'd0, rx_fifo_full}, 32'd0);

    // 5b: pop coincident with the ninth push, no overrun
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
    send_frame(8'h08, 1'b1, 1'b0, POP_AT);
    check_eq("t5b_ovr", ovr_cnt, 32'd1);
    check_eq("t5b_full", {31'd0, rx_fifo_full}, 32'd1);
    for (int i = 1; i < 9; i++) pop_expect($sformatf("t5b_%0d", i), 8'(i));
    check_eq("t5b_empty", {31'd0, rx_valid}, 32'd0);

    // 6: reset mid-DATA flushes FIFO and partial byte
    send_frame(8'h11, 1'b1, 1'b0, -1);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ((i == 2) || (i == 3)) ? 1'b1 : 1'b0;     // low nibble of 0x3C
      repeat (BIT) @(negedge clk);
    end
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("t6_rst_byte",  {24'd0, rx_byte}, 32'h00);
    rst = 1'b0;
    idle_bits(2);
    check_eq("t6_nopush", {31'd0, rx_valid}, 32'd0);
    check_eq("t6_ferr", ferr_cnt, 32'd1);
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    pop_expect("t6", 8'hC3);
    check_eq("t6_empty", {31'd0, rx_valid}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // 7: parity mismatch discards the byte
    send_frame(8'h03, 1'b1, 1'b1, -1);
    idle_bits(1);
    check_eq("t7_perr", perr_cnt, 32'd1);
    check_eq("t7_ferr", ferr_cnt, 32'd1);
    check_eq("t7_nopush", {31'd0, rx_valid}, 32'd0);
`else
    check_eq("t7_perr_tied", perr_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
